// File: rtl/count_display_pkg.sv
// count_display_pkg: shared types and constants for the count display driver.
// Holds the converter FSM state encoding, the display range limit, the
// active-low seven-segment glyphs (seg[6:0] = g,f,e,d,c,b,a) and the
// shift-add-3 nibble correction used by the binary-to-BCD converter.
package count_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  localparam logic [15:0] MAX_COUNT = 16'd9999;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Add 3 to every BCD nibble that is 5 or more, so the following left
  // shift carries correctly into the next decimal digit.
  function automatic logic [19:0] bcd_adjust(input logic [19:0] acc);
    logic [19:0] res;
    logic [3:0]  nib;
    res = 20'd0;
    for (int i = 0; i < 5; i++) begin
      nib = acc[i*4 +: 4];
      res[i*4 +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/count_display_driver_bcd_to_seg7.sv
// bcd_to_seg7: combinational decimal digit to active-low seven-segment glyph.
// Only 0..9 reach this decoder; any other code shows a blank digit.
module bcd_to_seg7
  import count_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  // Glyph lookup for one decimal digit.
  always_comb begin
    seg_o = SEG_BLANK;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_display_driver.sv
// count_display_driver: converts a 16-bit count into four BCD digits with a
// 16-iteration shift-add-3 converter, latches the result (or flags values
// above 9999), and scans the digits onto a multiplexed common-anode
// seven-segment display. Each digit stays enabled for REFRESH_DIV clocks.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 always lit); without it all four digits are always shown.
module count_display_driver
  import count_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        ovf,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);

  // Converter state
  conv_state_e  state_q;
  logic [15:0]  shreg_q;
  logic [19:0]  acc_q;
  logic [3:0]   iter_q;
  logic         over_q;
  logic         busy_q;
  logic         done_q;
  logic [15:0]  bcd_q;
  logic         ovf_q;

  // Display scan state
  logic [CNT_W-1:0] refresh_q;
  logic [CNT_W-1:0] refresh_d;
  logic [1:0]       digit_q;
  logic [1:0]       digit_d;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic [6:0]       seg_d;

  logic [19:0] acc_adj_s;
  logic [35:0] shift_s;
  logic        wrap_s;
  logic [3:0]  nibble_s;
  logic [6:0]  glyph_s;
  logic        blank_s;

  // One shift-add-3 step: correct the BCD nibbles, then shift {acc, shreg}.
  assign acc_adj_s = bcd_adjust(acc_q);
  assign shift_s   = {acc_adj_s, shreg_q} << 1;

  // Converter FSM with registered busy/done and the latched result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= 16'd0;
      acc_q   <= 20'd0;
      iter_q  <= 4'd0;
      over_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= 16'd0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            shreg_q <= value;
            acc_q   <= 20'd0;
            iter_q  <= 4'd0;
            over_q  <= (value > MAX_COUNT);
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc_q   <= shift_s[35:16];
          shreg_q <= shift_s[15:0];
          iter_q  <= iter_q + 4'd1;
          if (iter_q == 4'd15) begin
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          if (over_q) begin
            ovf_q <= 1'b1;
          end else begin
            bcd_q <= acc_q[15:0];
            ovf_q <= 1'b0;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Next refresh count and digit index; the digit advances on counter wrap.
  always_comb begin
    wrap_s = (refresh_q == REFRESH_LAST);
    if (wrap_s) begin
      refresh_d = '0;
      digit_d   = digit_q + 2'd1;
    end else begin
      refresh_d = refresh_q + CNT_W'(1);
      digit_d   = digit_q;
    end
  end

  // Select the nibble for the digit that will be enabled after this edge.
  always_comb begin
    nibble_s = 4'd0;
    case (digit_d)
      2'd0:    nibble_s = bcd_q[3:0];
      2'd1:    nibble_s = bcd_q[7:4];
      2'd2:    nibble_s = bcd_q[11:8];
      2'd3:    nibble_s = bcd_q[15:12];
      default: nibble_s = 4'd0;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit above the units is dark when it and every higher digit are zero.
  always_comb begin
    blank_s = 1'b0;
    case (digit_d)
      2'd0:    blank_s = 1'b0;
      2'd1:    blank_s = (bcd_q[15:4] == 12'd0);
      2'd2:    blank_s = (bcd_q[15:8] == 8'd0);
      2'd3:    blank_s = (bcd_q[15:12] == 4'd0);
      default: blank_s = 1'b0;
    endcase
  end
`else
  assign blank_s = 1'b0;
`endif

  bcd_to_seg7 u_seg7 (
    .digit_i (nibble_s),
    .seg_o   (glyph_s)
  );

  // Overflow dashes take priority over blanking and the decoded glyph.
  always_comb begin
    if (ovf_q) begin
      seg_d = SEG_DASH;
    end else if (blank_s) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = glyph_s;
    end
  end

  // Free-running scan: refresh counter, digit index and registered pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_q <= '0;
      digit_q   <= 2'd0;
      an_q      <= 4'b1110;
      seg_q     <= SEG_0;
    end else begin
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
      an_q      <= ~(4'b0001 << digit_d);
      seg_q     <= seg_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver: directed and random loads
// compared against a decimal-arithmetic model of the displayed count.
module tb_count_display_driver;

  localparam int DIV = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value = 16'd0;
  logic        load  = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;
  logic [3:0]  an;
  logic [6:0]  seg;

  int n_checks = 0;
  int n_fail   = 0;
  int edges    = 0;
  int m_val    = 0;
  bit m_ovf    = 1'b0;

  count_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .load  (load),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; sets the expected scan position.
  always @(posedge clk or negedge reset) begin
    if (!reset) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int pow10(input int p);
    int r = 1;
    for (int i = 0; i < p; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = 16'd0;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  function automatic logic [6:0] model_seg(input int pos);
    if (m_ovf) return 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
    if (pos > 0 && m_val < pow10(pos)) return 7'b1111111;
`endif
    return glyph((m_val / pow10(pos)) % 10);
  endfunction

  // Check the scanned pins for n cycles; the model count must be stable.
  task automatic check_display(input int n);
    int pos;
    logic [3:0] exp_an;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pos = (edges / DIV) % 4;
      exp_an = ~(4'b0001 << pos);
      check_eq("an", {28'd0, an}, {28'd0, exp_an});
      check_eq("seg", {25'd0, seg}, {25'd0, model_seg(pos)});
    end
  endtask

  // One conversion starting from IDLE at a falling edge; optionally drives
  // random loads while busy, which must all be ignored.
  task automatic convert(input logic [15:0] v, input bit noisy);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      check_eq("busy_conv", {31'd0, busy}, 32'd1);
      check_eq("done_early", {31'd0, done}, 32'd0);
      if (noisy) begin
        load  = 1'($urandom_range(0, 1));
        value = 16'($urandom);
      end
      @(negedge clk);
    end
    load = 1'b0;
    if (int'(v) <= 9999) begin
      m_val = int'(v);
      m_ovf = 1'b0;
    end else begin
      m_ovf = 1'b1;
    end
    check_eq("busy_end", {31'd0, busy}, 32'd0);
    check_eq("done_pulse", {31'd0, done}, 32'd1);
    check_eq("bcd", {16'd0, bcd}, {16'd0, to_bcd(m_val)});
    check_eq("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    @(negedge clk);
    check_eq("done_once", {31'd0, done}, 32'd0);
    check_eq("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] rv;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_bcd", {16'd0, bcd}, 32'd0);
    check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_an", {28'd0, an}, 32'hE);
    check_eq("rst_seg", {25'd0, seg}, 32'h40);
    reset = 1'b1;
    check_display(8);

    // Directed values, including the range boundary and overflow
    convert(16'd1234, 1'b0);
    check_display(20);
    convert(16'd9999, 1'b0);
    check_display(8);
    convert(16'd10000, 1'b0);
    check_display(16);
    convert(16'd7, 1'b0);
    check_display(16);
    convert(16'd0, 1'b0);
    check_display(16);

    // Back-to-back loads with load held high
    value = 16'd0;
    load  = 1'b1;
    @(negedge clk);
    for (int i = 0; i <= 16; i++) begin
      check_eq("b2b_busy1", {31'd0, busy}, 32'd1);
      if (i == 5) value = 16'd42;
      @(negedge clk);
    end
    m_val = 0;
    m_ovf = 1'b0;
    check_eq("b2b_done1", {31'd0, done}, 32'd1);
    check_eq("b2b_bcd1", {16'd0, bcd}, 32'h0000);
    check_eq("b2b_busy_gap", {31'd0, busy}, 32'd0);
    @(negedge clk);
    load = 1'b0;
    check_eq("b2b_busy2", {31'd0, busy}, 32'd1);
    check_eq("b2b_done_lo", {31'd0, done}, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check_eq("b2b_busy2", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    m_val = 42;
    check_eq("b2b_done2", {31'd0, done}, 32'd1);
    check_eq("b2b_bcd2", {16'd0, bcd}, 32'h0042);
    check_display(16);

    // Reset in the middle of a conversion
    value = 16'd5678;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    #1;
    m_val = 0;
    m_ovf = 1'b0;
    check_eq("mid_rst_bcd", {16'd0, bcd}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_an", {28'd0, an}, 32'hE);
    check_eq("mid_rst_seg", {25'd0, seg}, 32'h40);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("post_rst_done", {31'd0, done}, 32'd0);
      check_eq("post_rst_busy", {31'd0, busy}, 32'd0);
    end
    check_display(16);

    // Random values with ignored loads during conversion
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 3) == 0) rv = 16'($urandom_range(10000, 65535));
      else                           rv = 16'($urandom_range(0, 9999));
      convert(rv, 1'b1);
      check_display(6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_display_driver.md
# count_display_driver

Consumer of the 16-bit up/down count (range 0..9999): converts the binary value to four BCD digits with a sequential shift-add-3 converter, then drives a 4-digit multiplexed common-anode seven-segment display. It sits between the counter and the board display pins. It also republishes the latched BCD value and an overflow flag for other readers.

## Interface
Parameters:
- REFRESH_DIV, default 50000: clk cycles each digit stays enabled; legal range ≥ 2.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low.
- value  input  16  binary count to display, sampled only on an accepted load.
- load  input  1  conversion request, accepted only when busy=0.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when bcd/ovf update.
- bcd  output  16  latched result; 4 bits per digit, [3:0] = units.
- ovf  output  1  last accepted value > 9999.
- an  output  4  digit enables, active-low, one-hot-low; an[0] = units.
- seg  output  7  segments, active-low, seg[6:0] = g,f,e,d,c,b,a.

## Operation
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE: load=1 → capture value into shift register, clear 20-bit BCD accumulator and 4-bit iteration count, go to SHIFT.
- SHIFT: each cycle, add 3 to every accumulator nibble ≥ 5, then shift {acc, shreg} left by 1. After the 16th iteration, go to COMMIT.
- COMMIT, value ≤ 9999: bcd ← acc[15:0], ovf ← 0.
- COMMIT, value > 9999: bcd unchanged, ovf ← 1.
- COMMIT, both cases: done ← 1 for this one cycle, then return to IDLE.
- load while busy=1 or in COMMIT: ignored and not queued.
- Scan: a refresh counter runs 0..REFRESH_DIV-1. On wrap, the digit index advances 0→1→2→3→0. Scan runs freely and independently of the converter.
- Segment data: the selected bcd nibble goes through a hex-to-7seg decoder. Nibbles A–F cannot occur.
- ovf=1: every digit shows a dash (seg=7'b0111111).
- Reset (async, any state, including mid-conversion): FSM→IDLE, busy=0, done=0, bcd=0, ovf=0, refresh counter=0, digit index=0, an=4'b1110, seg=7'b1000000 ("0"). Partial conversion is discarded.

## Timing
- Edge 0 = the edge that samples load=1 in IDLE.
- Edges 1..16: SHIFT iterations.
- Edge 17: COMMIT. bcd, ovf and done are valid after edge 17.
- Load-to-result latency: 17 cycles.
- busy is high after edges 0..16 and low after edge 17. done is high only in the cycle after edge 17.
- A new load is accepted in the same cycle done is high, since busy=0.
- an and seg change together on the edge where the refresh counter wraps. Each digit is enabled for exactly REFRESH_DIV cycles.
- A bcd/ovf update takes effect on the displayed digit in the next cycle, without waiting for the digit to change.

## Configuration
- LEADING_ZERO_BLANK_EN defined: a digit i>0 is blanked (seg=7'b1111111, an still driven) when it and all higher digits are 0. Digit 0 is never blanked. ovf dashes override blanking.
- LEADING_ZERO_BLANK_EN undefined: all four digits always shown, including leading zeros.

## Structure
- Package count_display_pkg:
  - FSM state enum.
  - MAX_COUNT = 9999.
  - Segment constants SEG_BLANK, SEG_DASH, and the 0–9 active-low patterns.
- Sub-module bcd_to_seg7: combinational 4-bit nibble → 7-bit active-low pattern, instanced once after the digit mux.
- Top contains the converter FSM, the result registers and the scan counter.

## Test plan
- Reset release → bcd=16'h0000, ovf=0, busy=0, an=4'b1110, seg=7'b1000000.
- value=1234, load pulse → busy high 17 cycles; done pulse after edge 17; bcd=16'h1234. With REFRESH_DIV=4, an steps 1110→1101→1011→0111 every 4 cycles, with seg = 4,3,2,1 patterns in turn.
- value=9999 → bcd=16'h9999, ovf=0; then value=10000 → ovf=1, bcd stays 16'h9999, all digits seg=7'b0111111.
- load=1 held continuously with value=0 then 42 → back-to-back conversions with no idle gap. A load during busy is ignored; bcd=16'h0042 after the second done.
- Reset asserted at SHIFT iteration 8 of value=5678 → immediately bcd=0, busy=0. No done pulse after release.
- LEADING_ZERO_BLANK_EN defined, value=7 → digits 3..1 seg=7'b1111111, digit 0 seg=7'b1111000. value=0 → only digit 0 lit, showing "0".
